// File: rtl/lab5_pkg.sv
// Shared constants for the lab 5 front-end: debounce default and operand switch width.
package lab5_pkg;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int S_W                 = 8;
  localparam logic [S_W-1:0] S_RESET = '0;
endpackage

// File: rtl/input_conditioner_if.sv
// Raw pushbutton/switch inputs and conditioned outputs feeding the multiplier.
interface input_conditioner_if;
  import lab5_pkg::*;

  logic           Run_raw;
  logic           ClearA_LoadB_raw;
  logic [S_W-1:0] S_raw;
  logic           Run;
  logic           ClearA_LoadB;
  logic [S_W-1:0] S;
  logic           RunPress;
  logic           LoadPress;

  modport master (
    output Run_raw, ClearA_LoadB_raw, S_raw,
    input  Run, ClearA_LoadB, S, RunPress, LoadPress
  );

  modport slave (
    input  Run_raw, ClearA_LoadB_raw, S_raw,
    output Run, ClearA_LoadB, S, RunPress, LoadPress
  );
endinterface

// File: rtl/debouncer.sv
// One active-low pushbutton: 2-flop synchronizer, saturating stability counter,
// accepted level and a one-cycle press pulse on each accepted 1->0 transition.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = lab5_pkg::DEBOUNCE_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic             press_q;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync_p1 != stable);
  assign accept = differ && (cnt == CNT_MAX);

  // stage p0/p1: metastability filter; buttons idle high
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // debounce stage: counter only runs while the synced value disagrees with the level
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stable  <= 1'b1;
      cnt     <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= accept && !sync_p1;
      if (!differ || accept) begin
        cnt <= '0;
      end else begin
        cnt <= sat_inc(cnt);
      end
      if (accept) begin
        stable <= sync_p1;
      end
    end
  end

  assign level = stable;
  assign press = press_q;
endmodule

// File: rtl/input_conditioner.sv
// Conditions the multiplier's front-panel inputs: two debounced buttons with
// press pulses, plus a synchronized (not debounced) operand switch bank.
module input_conditioner
  import lab5_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input_conditioner_if.slave   bus
);
  logic [S_W-1:0] s_p0;
  logic [S_W-1:0] s_p1;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (bus.Run_raw),
    .level (bus.Run),
    .press (bus.RunPress)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .Clk   (Clk),
    .Reset (Reset),
    .raw   (bus.ClearA_LoadB_raw),
    .level (bus.ClearA_LoadB),
    .press (bus.LoadPress)
  );

  // stage p0/p1: per-bit switch synchronizer, switches are level inputs so no debounce
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s_p0 <= S_RESET;
      s_p1 <= S_RESET;
    end else begin
      s_p0 <= bus.S_raw;
      s_p1 <= s_p0;
    end
  end

  assign bus.S = s_p1;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4: vector table, hand-written
// corner sequences and a random phase against a sliding-window reference model.
module tb_input_conditioner;
  import lab5_pkg::*;

  localparam int N = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b0;

  input_conditioner_if bus ();

  input_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: raw samples per edge, index 0 oldest.  A level flips when the
  // N oldest of the last N+2 samples all oppose it (2 sync edges + N stable edges).
  bit             rh [N+2];
  bit             lh [N+2];
  logic [S_W-1:0] s_last;
  bit             m_run, m_ld, m_rp, m_lp;
  logic [S_W-1:0] m_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N + 2; i++) begin
      rh[i] = 1'b1;
      lh[i] = 1'b1;
    end
    s_last = '0;
    m_s    = '0;
    m_run  = 1'b1;
    m_ld   = 1'b1;
    m_rp   = 1'b0;
    m_lp   = 1'b0;
  endtask

  task automatic model_edge();
    bit all_r, all_l;
    for (int i = 0; i < N + 1; i++) begin
      rh[i] = rh[i+1];
      lh[i] = lh[i+1];
    end
    rh[N+1] = bus.Run_raw;
    lh[N+1] = bus.ClearA_LoadB_raw;
    all_r = 1'b1;
    all_l = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (rh[i] == m_run) all_r = 1'b0;
      if (lh[i] == m_ld)  all_l = 1'b0;
    end
    m_rp = all_r && m_run;
    m_lp = all_l && m_ld;
    if (all_r) m_run = ~m_run;
    if (all_l) m_ld  = ~m_ld;
    m_s    = s_last;
    s_last = bus.S_raw;
  endtask

  task automatic step(input bit r, input bit l, input logic [S_W-1:0] s);
    bus.Run_raw          = r;
    bus.ClearA_LoadB_raw = l;
    bus.S_raw            = s;
    @(posedge Clk);
    if (Reset) model_edge();
    #1;
    chk("model_Run",       32'(bus.Run),          32'(m_run));
    chk("model_ClearA",    32'(bus.ClearA_LoadB), 32'(m_ld));
    chk("model_RunPress",  32'(bus.RunPress),     32'(m_rp));
    chk("model_LoadPress", 32'(bus.LoadPress),    32'(m_lp));
    chk("model_S",         32'(bus.S),            32'(m_s));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_Run"},       32'(bus.Run),          32'(1'b1));
    chk({tag, "_ClearA"},    32'(bus.ClearA_LoadB), 32'(1'b1));
    chk({tag, "_RunPress"},  32'(bus.RunPress),     32'(1'b0));
    chk({tag, "_LoadPress"}, 32'(bus.LoadPress),    32'(1'b0));
    chk({tag, "_S"},         32'(bus.S),            32'(8'h00));
  endtask

  typedef struct {
    bit             run;
    bit             ld;
    logic [S_W-1:0] s;
    bit             e_run;
    bit             e_ld;
    bit             e_rp;
    bit             e_lp;
    logic [S_W-1:0] e_s;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit run, input bit ld, input logic [S_W-1:0] s,
                              input bit e_run, input bit e_ld, input bit e_rp,
                              input bit e_lp, input logic [S_W-1:0] e_s);
    vec_t v;
    v.run = run; v.ld = ld; v.s = s;
    v.e_run = e_run; v.e_ld = e_ld; v.e_rp = e_rp; v.e_lp = e_lp; v.e_s = e_s;
    vecs.push_back(v);
  endfunction

  initial begin
    int pulses, lpulses, at, lat;
    bit r_raw, l_raw;
    bit pat [5];

    // Row k is sampled on edge k+1 and checked just after it.
    for (int i = 0; i < 20; i++)   // clean Run press, level falls on 6th edge
      add(1'b0, 1'b1, 8'h02, (i < 5), 1'b1, (i == 5), 1'b0, 8'h02);
    for (int i = 0; i < 8; i++)    // release: level rises, no pulse
      add(1'b1, 1'b1, 8'h02, (i >= 5), 1'b1, 1'b0, 1'b0, 8'h02);
    for (int i = 0; i < 11; i++)   // 3-clock ClearA_LoadB glitch is rejected
      add(1'b1, (i >= 3), 8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
    for (int i = 0; i < 4; i++)    // switches appear exactly 2 edges later
      add(1'b1, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0, (i == 0) ? 8'h02 : 8'hFE);

    // Reset asserted with buttons pressed and switches set
    bus.Run_raw          = 1'b0;
    bus.ClearA_LoadB_raw = 1'b0;
    bus.S_raw            = 8'hAA;
    #12;
    chk_reset_vals("por");
    bus.Run_raw          = 1'b1;
    bus.ClearA_LoadB_raw = 1'b1;
    bus.S_raw            = 8'h02;
    @(posedge Clk);
    #3 Reset = 1'b1;
    model_reset();
    repeat (10) step(1'b1, 1'b1, 8'h02);

    foreach (vecs[i]) begin
      step(vecs[i].run, vecs[i].ld, vecs[i].s);
      chk($sformatf("vec%0d_Run", i),       32'(bus.Run),          32'(vecs[i].e_run));
      chk($sformatf("vec%0d_ClearA", i),    32'(bus.ClearA_LoadB), 32'(vecs[i].e_ld));
      chk($sformatf("vec%0d_RunPress", i),  32'(bus.RunPress),     32'(vecs[i].e_rp));
      chk($sformatf("vec%0d_LoadPress", i), 32'(bus.LoadPress),    32'(vecs[i].e_lp));
      chk($sformatf("vec%0d_S", i),         32'(bus.S),            32'(vecs[i].e_s));
    end

    // Bouncy press: one pulse, 6 edges after the last falling sample
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pulses = 0; at = -1;
    for (int k = 0; k < 20; k++) begin
      step((k < 5) ? pat[k] : 1'b0, 1'b1, 8'h02);
      if (bus.RunPress) begin
        pulses++;
        if (at < 0) at = k;
      end
    end
    chk("bouncy_pulses", 32'(pulses), 32'(1));
    chk("bouncy_at",     32'(at),     32'(9));
    repeat (10) step(1'b1, 1'b1, 8'h02);

    // Simultaneous presses: both pulses in the same cycle, once each
    pulses = 0; lpulses = 0; at = -1; lat = -1;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 8'h02);
      if (bus.RunPress)  begin pulses++;  if (at < 0)  at = k;  end
      if (bus.LoadPress) begin lpulses++; if (lat < 0) lat = k; end
    end
    chk("simul_run_pulses",  32'(pulses),  32'(1));
    chk("simul_load_pulses", 32'(lpulses), 32'(1));
    chk("simul_run_at",      32'(at),      32'(5));
    chk("simul_load_at",     32'(lat),     32'(5));
    repeat (10) step(1'b1, 1'b1, 8'h02);

    // Reset during a 2-clock-old press: count is discarded, full latency again
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'h5A);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    repeat (2) @(posedge Clk);
    #3 Reset = 1'b1;
    pulses = 0; at = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1, 8'h5A);
      if (bus.RunPress) begin
        pulses++;
        if (at < 0) at = k;
      end
    end
    chk("rst_reaccept_pulses", 32'(pulses), 32'(1));
    chk("rst_reaccept_at",     32'(at),     32'(6));
    repeat (10) step(1'b1, 1'b1, 8'h5A);

    // Random phase: slow button toggling so some presses are accepted
    r_raw = 1'b1; l_raw = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) r_raw = ~r_raw;
      if ($urandom_range(0, 5) == 0) l_raw = ~l_raw;
      step(r_raw, l_raw, 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
